// File: rtl/ras_ctrl_pkg.sv
// Shared types for the RAS sequencer: FSM state encoding and stage occupancy count type.
package ras_ctrl_pkg;

  localparam int RAS_SCRATCHPAD_DEPTH = 16;
  localparam int RAS_CNT_W            = $clog2(RAS_SCRATCHPAD_DEPTH) + 1;

  typedef logic [RAS_CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    RUN     = 2'd1,
    RECOVER = 2'd2,
    CLEAR   = 2'd3
  } ras_ctrl_state_e;

endpackage

// File: rtl/ras_ctrl_if.sv
// Fetch-side RAS op handshake: one op per cycle, accepted on op_valid & op_ready.
interface ras_ctrl_if #(
  parameter int WIDTH = 31
);
  logic             op_valid;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] target;
  logic             op_ready;

  modport master (output op_valid, call, ret, target, input  op_ready);
  modport slave  (input  op_valid, call, ret, target, output op_ready);
endinterface

// File: rtl/ras_ctrl_stage_cnt.sv
// Occupancy counter for one speculative stage scratchpad; clr wins over inc/dec.
module ras_ctrl_stage_cnt
  import ras_ctrl_pkg::*;
#(
  parameter int SCRATCHPAD_DEPTH = RAS_SCRATCHPAD_DEPTH,
  localparam int CW = $clog2(SCRATCHPAD_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_ni,
  input  logic          inc,
  input  logic          dec,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          empty,
  output logic          full
);

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni)  cnt <= '0;
    else if (clr) cnt <= '0;
    else          cnt <= cnt + CW'(inc) - CW'(dec);
  end

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(SCRATCHPAD_DEPTH));

`ifndef SYNTHESIS
  // Upstream ready logic must make wrap impossible.
  a_no_wrap: assert property (@(posedge clk) disable iff (!rst_ni)
    !clr |-> !(dec && !inc && empty) && !(inc && !dec && full));
`endif

endmodule

// File: rtl/ras_ctrl.sv
// Sequencer in front of the RAS: maps fetch ops and commit/kill events onto ras strobes,
// tracks per-stage occupancy for backpressure, and sequences init/clear/kill recovery.
module ras_ctrl
  import ras_ctrl_pkg::*;
#(
  parameter int STAGES           = 2,
  parameter int WIDTH            = 31,
  parameter int SCRATCHPAD_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              clr_i,
  ras_ctrl_if.slave         op,
  input  logic [STAGES-1:0] commit_i,
  output logic [STAGES-1:0] commit_ready_o,
  input  logic [STAGES-1:0] kill_i,
  output logic              ras_push_o,
  output logic              ras_pop_o,
  output logic [WIDTH-1:0]  ras_din_o,
  output logic [STAGES-1:0] ras_commit_o,
  output logic [STAGES-1:0] ras_flush_o,
  output logic              ras_rst_o,
  input  logic [WIDTH-1:0]  ras_dout_i,
  input  logic              ras_valid_i,
  output logic              pred_valid_o,
  output logic [WIDTH-1:0]  pred_addr_o,
  output logic              err_o
);

  localparam int CW = $clog2(SCRATCHPAD_DEPTH) + 1;

  localparam logic [1:0] ST_INIT    = 2'(INIT);
  localparam logic [1:0] ST_RUN     = 2'(RUN);
  localparam logic [1:0] ST_RECOVER = 2'(RECOVER);
  localparam logic [1:0] ST_CLEAR   = 2'(CLEAR);

  logic [1:0] state, state_nxt;

  logic [STAGES-1:0][CW-1:0] cnt;
  logic [STAGES-1:0]         empty, full, inc, dec, sclr;
  logic [STAGES-1:0]         kmask;   // stages at or below the highest kill
  logic                      live, kill_act, accept, commit_bad;

  // clr_i outranks everything, so it gates every strobe except ras_rst_o.
  assign live     = (state == ST_RUN) & ~clr_i;
  assign kill_act = ((state == ST_RUN) | (state == ST_RECOVER)) & ~clr_i & (|kill_i);

  assign op.op_ready = live & ~(|kill_i) & ~full[0];
  assign accept      = op.op_valid & op.op_ready;

  assign ras_push_o = accept & op.call;
  assign ras_pop_o  = accept & op.ret;
  assign ras_din_o  = accept ? op.target : '0;

  assign ras_flush_o  = kill_act ? kmask : '0;
  assign ras_commit_o = commit_i & commit_ready_o;
  assign ras_rst_o    = (state == ST_INIT) | clr_i;

  assign pred_valid_o = (state == ST_RUN) & ras_valid_i;
  assign pred_addr_o  = ras_dout_i;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    assign kmask[i] = |kill_i[STAGES-1:i];

    // The last stage drains to BRAM, so it never waits on a downstream slot.
    if (i < STAGES-1) begin : g_mid
      assign commit_ready_o[i] = live & ~kmask[i] & ~empty[i] & ~full[i+1];
    end else begin : g_last
      assign commit_ready_o[i] = live & ~kmask[i] & ~empty[i];
    end

    if (i == 0) begin : g_inc_op
      assign inc[i] = accept;
    end else begin : g_inc_cmt
      assign inc[i] = ras_commit_o[i-1];
    end

    assign dec[i]  = ras_commit_o[i];
    assign sclr[i] = clr_i | ras_flush_o[i];

    ras_ctrl_stage_cnt #(
      .SCRATCHPAD_DEPTH(SCRATCHPAD_DEPTH)
    ) u_cnt (
      .clk   (clk),
      .rst_ni(rst_ni),
      .inc   (inc[i]),
      .dec   (dec[i]),
      .clr   (sclr[i]),
      .cnt   (cnt[i]),
      .empty (empty[i]),
      .full  (full[i])
    );
  end

  // Commits swallowed by a kill or a clear are expected; anything else is a protocol error.
  assign commit_bad = ~clr_i & (|(commit_i & ~commit_ready_o & ~ras_flush_o));

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni)         err_o <= 1'b0;
    else if (commit_bad) err_o <= 1'b1;
  end

  always_comb begin
    state_nxt = state;
    if (clr_i) begin
      state_nxt = ST_CLEAR;
    end else begin
      case (state)
        ST_INIT:    state_nxt = ST_RUN;
        ST_RUN:     state_nxt = kill_act ? ST_RECOVER : ST_RUN;
        ST_RECOVER: state_nxt = kill_act ? ST_RECOVER : ST_RUN;
        ST_CLEAR:   state_nxt = ST_RUN;
        default:    state_nxt = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) state <= ST_INIT;
    else         state <= state_nxt;
  end

endmodule
